// File: rtl/arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arbiter_pkg
//  Description : Shared types for the two-requester fixed-priority arbiter.
//                Holds the FSM state encoding. The 2'b11 code is unused and
//                is treated as illegal by the arbiter, which recovers to IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
package arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

endpackage : arbiter_pkg
`default_nettype wire

// File: rtl/arbiter_2req.sv
`default_nettype none
// ============================================================================
//  Module      : arbiter_2req
//  Description : Two-requester fixed-priority bus arbiter with grant locking.
//                req_0 has priority over req_1 when both request from IDLE.
//                A granted requester keeps the grant while its request stays
//                high. There is no preemption, and a grant always returns to
//                IDLE before the other requester can be served.
//  Ports       : clk    - clock, rising edge
//                reset  - synchronous, active-high reset
//                req_0  - request from requester 0 (high priority)
//                req_1  - request from requester 1 (low priority)
//                gnt_0  - registered grant to requester 0
//                gnt_1  - registered grant to requester 1
//  Revision    : 1.0 - initial release
// ============================================================================
module arbiter_2req
    import arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_0,
    input  logic req_1,
    output logic gnt_0,
    output logic gnt_1
);

    state_t r_state;
    state_t w_next_state;
    logic   r_gnt_0;
    logic   r_gnt_1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. A grant can only be entered from IDLE, which both
    // gives the lock behaviour and forces an IDLE cycle between grants to
    // different requesters.
    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            IDLE: begin
                if (req_0) begin
                    w_next_state = GNT0;
                end else if (req_1) begin
                    w_next_state = GNT1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            GNT0:    w_next_state = req_0 ? GNT0 : IDLE;
            GNT1:    w_next_state = req_1 ? GNT1 : IDLE;
            default: w_next_state = IDLE;  // illegal 2'b11 recovers to IDLE
        endcase
    end

    // Output register. The grants are decoded from the next state and
    // registered, so each grant flop always equals (state == GNTx) and the
    // outputs come straight from flops with no decode logic behind them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt_0 <= 1'b0;
            r_gnt_1 <= 1'b0;
        end else begin
            r_gnt_0 <= (w_next_state == GNT0);
            r_gnt_1 <= (w_next_state == GNT1);
        end
    end

    assign gnt_0 = r_gnt_0;
    assign gnt_1 = r_gnt_1;

endmodule : arbiter_2req
`default_nettype wire

// File: tb/tb_arbiter_2req.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arbiter_2req
//  Description : Self-checking bench for arbiter_2req. Directed scenarios
//                compare the grants against expected tables. A randomized
//                phase compares them against a reference model that tracks
//                which requester, if any, currently owns the bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arbiter_2req;

    logic clk;
    logic reset;
    logic req_0;
    logic req_1;
    logic gnt_0;
    logic gnt_1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the owner of the bus (-1 means nobody owns it).
    int   m_owner = -1;
    logic exp_g0;
    logic exp_g1;

    arbiter_2req dut (
        .clk   (clk),
        .reset (reset),
        .req_0 (req_0),
        .req_1 (req_1),
        .gnt_0 (gnt_0),
        .gnt_1 (gnt_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, advance the model at the edge and
    // return 1 time unit after that edge, when the outputs are stable.
    task automatic tick(input logic r, input logic a, input logic b);
        logic want;
        reset = r;
        req_0 = a;
        req_1 = b;
        @(posedge clk);
        if (r) begin
            m_owner = -1;
        end else if (m_owner < 0) begin
            // Free bus: the lowest-numbered requester wins.
            m_owner = a ? 0 : (b ? 1 : -1);
        end else begin
            // Owned bus: the owner keeps it only while it still requests.
            want = (m_owner == 0) ? a : b;
            if (!want) m_owner = -1;
        end
        exp_g0 = (m_owner == 0);
        exp_g1 = (m_owner == 1);
        #1;
    endtask

    // Each table entry is {reset, req_0, req_1} and the expected
    // {gnt_0, gnt_1} after that edge.
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if ({gnt_0, gnt_1} !== 2'b00) begin
                n_bad++;
                $display("FAIL reset[%0d]: got gnt=%b%b, expected 00", i, gnt_0, gnt_1);
            end
        end
    endtask

    task automatic test_req0_single();
        logic [2:0] stim [2] = '{3'b010, 3'b000};
        logic [1:0] expv [2] = '{2'b10, 2'b00};
        for (int i = 0; i < 2; i++) begin
            tick(stim[i][2], stim[i][1], stim[i][0]);
            n_cmp++;
            if ({gnt_0, gnt_1} !== expv[i]) begin
                n_bad++;
                $display("FAIL req0_single[%0d]: got gnt=%b%b, expected %b", i, gnt_0, gnt_1, expv[i]);
            end
        end
    endtask

    task automatic test_req1_single();
        logic [2:0] stim [2] = '{3'b001, 3'b000};
        logic [1:0] expv [2] = '{2'b01, 2'b00};
        for (int i = 0; i < 2; i++) begin
            tick(stim[i][2], stim[i][1], stim[i][0]);
            n_cmp++;
            if ({gnt_0, gnt_1} !== expv[i]) begin
                n_bad++;
                $display("FAIL req1_single[%0d]: got gnt=%b%b, expected %b", i, gnt_0, gnt_1, expv[i]);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] stim [2] = '{3'b011, 3'b000};
        logic [1:0] expv [2] = '{2'b10, 2'b00};
        for (int i = 0; i < 2; i++) begin
            tick(stim[i][2], stim[i][1], stim[i][0]);
            n_cmp++;
            if ({gnt_0, gnt_1} !== expv[i]) begin
                n_bad++;
                $display("FAIL simultaneous[%0d]: got gnt=%b%b, expected %b", i, gnt_0, gnt_1, expv[i]);
            end
        end
    endtask

    // req_0 arrives during a req_1 grant: no preemption, one IDLE cycle,
    // then req_0 is served.
    task automatic test_no_preempt();
        logic [2:0] stim [6] = '{3'b001, 3'b011, 3'b011, 3'b010, 3'b010, 3'b000};
        logic [1:0] expv [6] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00};
        for (int i = 0; i < 6; i++) begin
            tick(stim[i][2], stim[i][1], stim[i][0]);
            n_cmp++;
            if ({gnt_0, gnt_1} !== expv[i]) begin
                n_bad++;
                $display("FAIL no_preempt[%0d]: got gnt=%b%b, expected %b", i, gnt_0, gnt_1, expv[i]);
            end
        end
    endtask

    // Handoff in the other direction: GNT0 -> IDLE -> GNT1.
    task automatic test_back_to_back();
        logic [2:0] stim [5] = '{3'b010, 3'b011, 3'b001, 3'b001, 3'b000};
        logic [1:0] expv [5] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b00};
        for (int i = 0; i < 5; i++) begin
            tick(stim[i][2], stim[i][1], stim[i][0]);
            n_cmp++;
            if ({gnt_0, gnt_1} !== expv[i]) begin
                n_bad++;
                $display("FAIL back_to_back[%0d]: got gnt=%b%b, expected %b", i, gnt_0, gnt_1, expv[i]);
            end
        end
    endtask

    // Reset while a grant is held, then the grant returns after release.
    task automatic test_reset_mid_grant();
        logic [2:0] stim [5] = '{3'b010, 3'b110, 3'b111, 3'b010, 3'b000};
        logic [1:0] expv [5] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b00};
        for (int i = 0; i < 5; i++) begin
            tick(stim[i][2], stim[i][1], stim[i][0]);
            n_cmp++;
            if ({gnt_0, gnt_1} !== expv[i]) begin
                n_bad++;
                $display("FAIL reset_mid_grant[%0d]: got gnt=%b%b, expected %b", i, gnt_0, gnt_1, expv[i]);
            end
        end
    endtask

    // Random requests, held for several cycles at a time so that locking
    // and handoffs are exercised; occasional resets. Also checks that no
    // grant ever moves directly from one requester to the other.
    task automatic test_random();
        logic a = 1'b0;
        logic b = 1'b0;
        logic r;
        logic p0 = gnt_0;
        logic p1 = gnt_1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 1) == 1;
            r = ($urandom_range(0, 40) == 0);
            tick(r, a, b);
            n_cmp++;
            if ({gnt_0, gnt_1} !== {exp_g0, exp_g1}) begin
                n_bad++;
                $display("FAIL random[%0d]: got gnt=%b%b, expected %b%b", i, gnt_0, gnt_1, exp_g0, exp_g1);
            end
            n_cmp++;
            if ((p0 && gnt_1) || (p1 && gnt_0)) begin
                n_bad++;
                $display("FAIL handoff[%0d]: got gnt %b%b -> %b%b, expected an idle cycle between", i, p0, p1, gnt_0, gnt_1);
            end
            p0 = gnt_0;
            p1 = gnt_1;
        end
    endtask

    initial begin
        reset = 1'b1;
        req_0 = 1'b0;
        req_1 = 1'b0;
        test_reset();
        test_req0_single();
        test_req1_single();
        test_simultaneous();
        test_no_preempt();
        test_back_to_back();
        test_reset_mid_grant();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_arbiter_2req
`default_nettype wire
